// File: rtl/debug_display_mux.sv
// Debug display multiplexer: selects one probe channel (manual, auto-scan or
// snapshot), registers it, and drives an active-low 7-segment hex decode of it.
module debug_display_mux #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 16,
    parameter int DWELL  = 50000000,
    localparam int DIGITS = DATA_W / 4,
    localparam int SW_W   = $clog2(NUM_CH)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_CH*DATA_W-1:0] probe_bus,
    input  logic [SW_W-1:0]          sel,
    input  logic [1:0]               mode,
    input  logic                     step,
    output logic [SW_W-1:0]          cur_ch,
    output logic [DATA_W-1:0]        disp_val,
    output logic                     frozen,
    output logic [DIGITS*7-1:0]      seg
);

    localparam int CNT_W = $clog2(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SW_W-1:0]  CH_LAST  = SW_W'(NUM_CH - 1);

    localparam logic [1:0] MODE_AUTO = 2'b01;
    localparam logic [1:0] MODE_SNAP = 2'b10;

    logic [SW_W-1:0]   cur_ch_q, cur_ch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] disp_q, disp_d;
    logic              frozen_q, frozen_d;
    logic [DATA_W-1:0] ch_val_s;
    logic [SW_W-1:0]   ch_next_s;
    logic              sel_ok_s;

    // Active-low abcdefg pattern for one hex nibble (bit 6 = a, bit 0 = g).
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            4'hF:    s = 7'b0111000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Channel mux, select qualification and next-channel wrap.
    always_comb begin
        ch_val_s = probe_bus[cur_ch_q*DATA_W +: DATA_W];
        sel_ok_s = (int'(sel) < NUM_CH);
        if (cur_ch_q == CH_LAST) begin
            ch_next_s = '0;
        end else begin
            ch_next_s = cur_ch_q + SW_W'(1);
        end
    end

    // Next-state: channel pointer, dwell counter, display register, freeze flag.
    always_comb begin
        cur_ch_d = cur_ch_q;
        cnt_d    = '0;
        disp_d   = disp_q;
        frozen_d = (mode == MODE_SNAP);

        case (mode)
            MODE_AUTO: begin
                // A step on the terminal-count cycle still advances only once.
                if (step || (cnt_q == CNT_LAST)) begin
                    cur_ch_d = ch_next_s;
                    cnt_d    = '0;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (sel_ok_s) begin
                    cur_ch_d = sel;
                end else begin
                    cur_ch_d = cur_ch_q;
                end
            end
        endcase

        // Freeze keys off the live mode input so the hold starts on the first edge.
        if ((mode != MODE_SNAP) || step) begin
            disp_d = ch_val_s;
        end else begin
            disp_d = disp_q;
        end
    end

    // State registers, asynchronously cleared.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cur_ch_q <= '0;
            cnt_q    <= '0;
            disp_q   <= '0;
            frozen_q <= 1'b0;
        end else begin
            cur_ch_q <= cur_ch_d;
            cnt_q    <= cnt_d;
            disp_q   <= disp_d;
            frozen_q <= frozen_d;
        end
    end

    assign cur_ch   = cur_ch_q;
    assign disp_val = disp_q;
    assign frozen   = frozen_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign seg[g*7 +: 7] = hex7(disp_q[g*4 +: 4]);
    end

endmodule

// File: tb/tb_debug_display_mux.sv
// Randomized scoreboard bench for debug_display_mux (4 channels, 16-bit, dwell 4)
// plus a 3-channel instance for the out-of-range select case.
module tb_debug_display_mux;

    localparam int NC  = 4;
    localparam int DW  = 16;
    localparam int DWL = 4;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] disp;
        logic        frz;
        logic [27:0] seg;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [63:0] probe_bus;
    logic [1:0]  sel = 2'd0;
    logic [1:0]  mode = 2'd0;
    logic        step = 1'b0;
    logic [1:0]  cur_ch;
    logic [15:0] disp_val;
    logic        frozen;
    logic [27:0] seg;

    logic [1:0]  sel3 = 2'd0;
    logic [1:0]  mode3 = 2'd0;
    logic        step3 = 1'b0;
    logic [1:0]  cur_ch3;
    logic [15:0] disp3;
    logic        frozen3;
    logic [27:0] seg3;

    logic [15:0] pr [NC];
    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    int          m_ch, m_cnt;
    logic [15:0] m_disp;
    logic        m_frz;

    always #5 Clk = ~Clk;

    always_comb begin
        probe_bus = '0;
        for (int k = 0; k < NC; k++) probe_bus[k*16 +: 16] = pr[k];
    end

    debug_display_mux #(.NUM_CH(NC), .DATA_W(DW), .DWELL(DWL)) u_dut (
        .Clk(Clk), .Reset(Reset), .probe_bus(probe_bus), .sel(sel), .mode(mode),
        .step(step), .cur_ch(cur_ch), .disp_val(disp_val), .frozen(frozen), .seg(seg)
    );

    debug_display_mux #(.NUM_CH(3), .DATA_W(DW), .DWELL(DWL)) u_dut3 (
        .Clk(Clk), .Reset(Reset), .probe_bus(probe_bus[47:0]), .sel(sel3), .mode(mode3),
        .step(step3), .cur_ch(cur_ch3), .disp_val(disp3), .frozen(frozen3), .seg(seg3)
    );

    function automatic logic [6:0] seg_ref(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    function automatic logic [27:0] segs(input logic [15:0] v);
        return {seg_ref(v[15:12]), seg_ref(v[11:8]), seg_ref(v[7:4]), seg_ref(v[3:0])};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // One clock: drive inputs on the falling edge, predict the post-edge state, queue it.
    task automatic cycle(input logic [1:0] md, input logic [1:0] s, input logic st);
        logic [15:0] nd;
        exp_t e;
        @(negedge Clk);
        mode = md; sel = s; step = st;
        nd = ((md != 2'b10) || st) ? pr[m_ch] : m_disp;
        if (md == 2'b01) begin
            if (st || (m_cnt == DWL - 1)) begin
                m_ch  = (m_ch + 1) % NC;
                m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else begin
            m_cnt = 0;
            if (int'(s) < NC) m_ch = int'(s);
        end
        m_disp = nd;
        m_frz  = (md == 2'b10);
        e.ch = 2'(m_ch); e.disp = m_disp; e.frz = m_frz; e.seg = segs(m_disp);
        sb.push_back(e);
        @(posedge Clk);
        #2;
        step = 1'b0;
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        chk("rst_cur_ch", 32'(cur_ch), 32'd0);
        chk("rst_disp", 32'(disp_val), 32'd0);
        chk("rst_frozen", 32'(frozen), 32'd0);
        chk("rst_seg", 32'(seg), 32'(28'h0204081));
        chk("rst_cur_ch3", 32'(cur_ch3), 32'd0);
        @(posedge Clk);
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        m_ch = 0; m_cnt = 0; m_disp = 16'h0; m_frz = 1'b0;
    endtask

    // Monitor: every clock the DUT presents a new state; compare against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_cur_ch", 32'(cur_ch), 32'(e.ch));
                chk("sb_disp", 32'(disp_val), 32'(e.disp));
                chk("sb_frozen", 32'(frozen), 32'(e.frz));
                chk("sb_seg", 32'(seg), 32'(e.seg));
            end
        end
    end

    initial begin
        pr[0] = 16'h1234; pr[1] = 16'hABCD; pr[2] = 16'h00F0; pr[3] = 16'hBEEF;
        m_ch = 0; m_cnt = 0; m_disp = 16'h0; m_frz = 1'b0;

        #3;
        chk("init_cur_ch", 32'(cur_ch), 32'd0);
        chk("init_disp", 32'(disp_val), 32'd0);
        chk("init_seg", 32'(seg), 32'(28'h0204081));
        @(posedge Clk);
        @(posedge Clk);
        #2;
        Reset = 1'b0;

        // Manual select latency and decode; 3-channel build rejects sel=3.
        sel3 = 2'd2;
        cycle(2'b00, 2'd1, 1'b0);
        chk("man_cur_ch", 32'(cur_ch), 32'd1);
        chk("inv_cur_ch3_a", 32'(cur_ch3), 32'd2);
        sel3 = 2'd3;
        cycle(2'b00, 2'd1, 1'b0);
        chk("man_disp", 32'(disp_val), 32'hABCD);
        chk("man_seg", 32'(seg), 32'({7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010}));
        chk("inv_cur_ch3_b", 32'(cur_ch3), 32'd2);
        chk("inv_disp3", 32'(disp3), 32'h00F0);

        // Auto-scan wrap.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(2'b01, 2'd0, 1'b0);
            chk("auto_cur_ch", 32'(cur_ch), 32'(((i + 1) / 4) % 4));
        end

        // Step on terminal count with channel 3.
        do_reset();
        for (int i = 0; i < 15; i++) cycle(2'b01, 2'd0, 1'b0);
        chk("coll_pre_ch", 32'(cur_ch), 32'd3);
        cycle(2'b01, 2'd0, 1'b1);
        chk("coll_cur_ch", 32'(cur_ch), 32'd0);
        for (int i = 0; i < 3; i++) cycle(2'b01, 2'd0, 1'b0);
        chk("coll_full_dwell", 32'(cur_ch), 32'd0);
        cycle(2'b01, 2'd0, 1'b0);
        chk("coll_next_ch", 32'(cur_ch), 32'd1);

        // Reset mid-dwell at channel 2, then scan restarts at 0.
        do_reset();
        for (int i = 0; i < 9; i++) cycle(2'b01, 2'd0, 1'b0);
        chk("mid_pre_ch", 32'(cur_ch), 32'd2);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(2'b01, 2'd0, 1'b0);
        chk("mid_restart_ch", 32'(cur_ch), 32'd1);

        // Snapshot hold and single-step capture.
        do_reset();
        cycle(2'b00, 2'd0, 1'b0);
        cycle(2'b00, 2'd0, 1'b0);
        chk("snap_pre_disp", 32'(disp_val), 32'h1234);
        cycle(2'b10, 2'd0, 1'b0);
        pr[0] = 16'h5555;
        cycle(2'b10, 2'd0, 1'b0);
        chk("snap_hold_disp", 32'(disp_val), 32'h1234);
        chk("snap_frozen", 32'(frozen), 32'd1);
        cycle(2'b10, 2'd0, 1'b1);
        chk("snap_step_disp", 32'(disp_val), 32'h5555);
        cycle(2'b00, 2'd0, 1'b0);
        chk("snap_exit_frozen", 32'(frozen), 32'd0);

        // Randomized traffic with mode held for random stretches.
        begin
            logic [1:0] md;
            int hold;
            md = 2'b00; hold = 0;
            for (int i = 0; i < 600; i++) begin
                if (hold == 0) begin
                    md   = 2'($urandom_range(0, 3));
                    hold = $urandom_range(1, 20);
                end
                hold = hold - 1;
                if ($urandom_range(0, 7) == 0) pr[$urandom_range(0, NC - 1)] = 16'($urandom);
                if ($urandom_range(0, 150) == 0) do_reset();
                cycle(md, 2'($urandom_range(0, 3)), ($urandom_range(0, 6) == 0));
            end
        end

        @(negedge Clk);
        @(negedge Clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
